// File: rtl/filter_sched_pkg.sv
// Shared constants and types for the uDMA filter scheduler.
// Register map offsets, control values, FSM state enum and job layout.
package filter_sched_pkg;

  localparam int JOB_WORDS = 7;

  localparam logic [4:0] TX0_SADDR = 5'h00;
  localparam logic [4:0] TX0_SIZE  = 5'h02;
  localparam logic [4:0] TX1_SADDR = 5'h05;
  localparam logic [4:0] TX1_SIZE  = 5'h07;
  localparam logic [4:0] RX_SADDR  = 5'h0A;
  localparam logic [4:0] RX_SIZE   = 5'h0C;
  localparam logic [4:0] MODE_ADDR = 5'h15;

  localparam logic [4:0] CFG_ADDR_LUT [0:JOB_WORDS-1] = '{
    TX0_SADDR,
    TX0_SIZE,
    TX1_SADDR,
    TX1_SIZE,
    RX_SADDR,
    RX_SIZE,
    MODE_ADDR
  };

  localparam logic [4:0]  FILT_CTRL_ADDR = 5'h16;
  localparam logic [31:0] FILT_START_VAL = 32'h0000_0001;
  localparam logic [31:0] FILT_STOP_VAL  = 32'h0000_0002;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARB      = 3'd1,
    ST_WRITE    = 3'd2,
    ST_START    = 3'd3,
    ST_WAIT_EOT = 3'd4,
    ST_ABORT    = 3'd5,
    ST_DONE     = 3'd6
  } sched_state_e;

  typedef logic [JOB_WORDS-1:0][31:0] job_t;

endpackage

// File: rtl/filter_rr_arb.sv
// Combinational round-robin arbiter for the filter scheduler.
// Grants the first set request at or after the pointer, wrapping.
module filter_rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 vld_o
);

  localparam int IW = $clog2(N);

  // scan upward from the pointer; first hit wins
  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      if (!vld_o && req_i[j[IW-1:0]]) begin
        vld_o              = 1'b1;
        gnt_o[j[IW-1:0]]   = 1'b1;
        idx_o              = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/udma_filter_sched.sv
// Shares one uDMA filter among several requesters.
// Arbitrates jobs, programs the filter cfg bus, waits for EOT or timeout.
module udma_filter_sched
  import filter_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT_W = 20
) (
  input  logic                       sys_clk_i,
  input  logic                       rst_i,
  input  logic [TIMEOUT_W-1:0]       timeout_cyc_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  job_t [NUM_REQ-1:0]         job_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [NUM_REQ-1:0]         done_o,
  output logic                       err_o,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic [31:0]                cfg_data_o,
  output logic [4:0]                 cfg_addr_o,
  output logic                       cfg_valid_o,
  output logic                       cfg_rwn_o,
  input  logic                       cfg_ready_i,
  input  logic                       eot_event_i,
  input  logic                       act_event_i
);

  localparam int OW = $clog2(NUM_REQ);

  sched_state_e state_q, state_d;

  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        rr_q, rr_d;
  logic [2:0]           k_q, k_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 err_q, err_d;
  logic                 skip_q, skip_d;
  logic [7:0]           act_q, act_d;

  logic [NUM_REQ-1:0] own_oh;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [OW-1:0]      arb_idx;
  logic               arb_vld;
  logic               to_hit;

  logic [NUM_REQ-1:0] gnt_c;
  logic [NUM_REQ-1:0] done_c;
  logic               cfg_v;
  logic [4:0]         cfg_a;
  logic [31:0]        cfg_w;

  assign own_oh = NUM_REQ'(1) << owner_q;

  // right after DONE the finishing owner must not win again
  assign arb_req = skip_q ? (req_i & ~own_oh) : req_i;

  assign to_hit = (timeout_cyc_i != '0) &&
                  (wd_q == timeout_cyc_i - TIMEOUT_W'(1));

  filter_rr_arb #(
    .N (NUM_REQ)
  ) u_arb (
    .req_i (arb_req),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  // next-state, datapath updates and cfg/pulse outputs
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    k_d     = k_q;
    wd_d    = wd_q;
    err_d   = err_q;
    skip_d  = skip_q;
    act_d   = act_q;
    gnt_c   = '0;
    done_c  = '0;
    cfg_v   = 1'b0;
    cfg_a   = '0;
    cfg_w   = '0;

    if (act_event_i && act_q != 8'hFF) act_d = act_q + 8'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (|req_i) state_d = ST_ARB;
      end
      ST_ARB: begin
        skip_d = 1'b0;
        act_d  = '0;
        if (arb_vld) begin
          owner_d = arb_idx;
          rr_d    = (arb_idx == OW'(NUM_REQ - 1)) ? '0
                  : arb_idx + OW'(1);
          k_d     = '0;
          gnt_c   = arb_gnt;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        cfg_v = 1'b1;
        cfg_a = CFG_ADDR_LUT[k_q];
        cfg_w = job_i[owner_q][k_q];
        if (cfg_ready_i) begin
          if (k_q == 3'(JOB_WORDS - 1)) begin
            k_d     = '0;
            state_d = ST_START;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      ST_START: begin
        cfg_v = 1'b1;
        cfg_a = FILT_CTRL_ADDR;
        cfg_w = FILT_START_VAL;
        if (cfg_ready_i) begin
          wd_d    = '0;
          state_d = ST_WAIT_EOT;
        end
      end
      ST_WAIT_EOT: begin
        if (wd_q != '1) wd_d = wd_q + TIMEOUT_W'(1);
        if (eot_event_i) begin
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (to_hit) begin
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        cfg_v = 1'b1;
        cfg_a = FILT_CTRL_ADDR;
        cfg_w = FILT_STOP_VAL;
        if (cfg_ready_i) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_c = own_oh;
        if (|req_i) begin
          skip_d  = 1'b1;
          state_d = ST_ARB;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      k_q     <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      skip_q  <= 1'b0;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      k_q     <= k_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      skip_q  <= skip_d;
      act_q   <= act_d;
    end
  end

  // reset kills the cfg request in the same cycle, no STOP write
  assign cfg_valid_o = cfg_v & ~rst_i;
  assign cfg_addr_o  = rst_i ? '0 : cfg_a;
  assign cfg_data_o  = rst_i ? '0 : cfg_w;
  assign cfg_rwn_o   = 1'b0;
  assign gnt_o       = rst_i ? '0 : gnt_c;
  assign done_o      = rst_i ? '0 : done_c;
  assign err_o       = (state_q == ST_DONE) & err_q & ~rst_i;
  assign busy_o      = (state_q != ST_IDLE);
  assign owner_o     = owner_q;

endmodule

// File: doc/udma_filter_sched.md
Name: udma_filter_sched

Overview:
- Shares one uDMA filter instance among NUM_REQ requesters (cores or accelerators).
- Round-robin arbitrates job requests and programs the filter over its 5-bit cfg bus (seven configuration writes, then a start write).
- Waits for the filter EOT event, or a timeout, then returns done/error to the owning requester.
- Sits between the requester fabric and the filter's cfg port; events_o[0] of the filter wrap drives eot_event_i.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_W, 20, width of the watchdog counter
JOB_WORDS, 7, configuration words per job (fixed by package LUT)

Ports:
sys_clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
timeout_cyc_i  in  TIMEOUT_W  watchdog limit in cycles; 0 disables the watchdog
req_i  in  NUM_REQ  per-requester job request, level-sensitive
job_i  in  NUM_REQx7x32  per-requester job words; must stay stable while req_i is high and until done_o
gnt_o  out  NUM_REQ  one-hot, 1-cycle pulse when the job is accepted
done_o  out  NUM_REQ  one-hot, 1-cycle pulse at job end
err_o  out  1  valid with done_o; 1 = timeout abort
busy_o  out  1  scheduler not in IDLE
owner_o  out  clog2(NUM_REQ)  index of the current owner
cfg_data_o  out  32  write data to filter
cfg_addr_o  out  5  register offset
cfg_valid_o  out  1  cfg request
cfg_rwn_o  out  1  always 0 (write)
cfg_ready_i  in  1  filter accepts the cfg beat
eot_event_i  in  1  filter end-of-transfer pulse
act_event_i  in  1  filter activity event; counted only (see below)

Behaviour:
- Reset state:
  - All outputs 0.
  - State = IDLE; round-robin pointer = 0; word index = 0; watchdog = 0.
- FSM states: IDLE, ARB, WRITE, START, WAIT_EOT, ABORT, DONE.
- IDLE: when any req_i is set, go to ARB next cycle.
- ARB (1 cycle):
  - Pick the first set req_i at or after rr_ptr, wrapping modulo NUM_REQ.
  - Latch owner, pulse gnt_o[owner], clear the word index, go to WRITE.
  - If req_i has dropped to all zero, return to IDLE and pulse no gnt_o.
- Round-robin pointer: rr_ptr = owner+1 (mod NUM_REQ), updated in ARB.
- WRITE:
  - Drive cfg_valid_o=1, cfg_addr_o=CFG_ADDR_LUT[k], cfg_data_o=job_i[owner][k].
  - Hold all three stable until cfg_ready_i is high in the same cycle.
  - On that handshake, k increments. When k=JOB_WORDS-1 completes, go to START.
  - cfg_valid_o may stay high across back-to-back beats, giving 1 beat/cycle when ready is high.
- START:
  - Drive a cfg write of FILT_START_VAL to FILT_CTRL_ADDR, held until ready.
  - On handshake, clear the watchdog and go to WAIT_EOT.
- WAIT_EOT:
  - The watchdog increments every cycle.
  - If eot_event_i is high, go to DONE with err=0.
  - Else, if timeout_cyc_i!=0 and watchdog==timeout_cyc_i-1, go to ABORT.
  - If eot_event_i and the timeout hit in the same cycle, EOT wins (err=0).
- ABORT: cfg write of FILT_STOP_VAL to FILT_CTRL_ADDR, held until ready, then go to DONE with err=1.
- DONE (1 cycle):
  - Pulse done_o[owner] with err_o.
  - Go to ARB if any req_i is set (the owner's own req_i is ignored in that ARB evaluation), else go to IDLE.
- EOT outside WAIT_EOT: ignored.
- act_event_i: increments a saturating 8-bit internal act counter per job (debug only, no port). Cleared in ARB.
- Job turnaround: minimum latency from req to first cfg_valid_o is 2 cycles (IDLE→ARB→WRITE).
- Reset mid-operation (rst_i high in any state):
  - Return to IDLE next edge and drop cfg_valid_o immediately; no STOP write is issued.
  - Software re-initialises the filter.
- Watchdog: does not wrap, because the compare happens before overflow; a timeout_cyc_i of all-ones is legal.

Decomposition:
- Package filter_sched_pkg holds:
  - CFG_ADDR_LUT[0:6]: TX0_SADDR, TX0_SIZE, TX1_SADDR, TX1_SIZE, RX_SADDR, RX_SIZE, MODE offsets.
  - FILT_CTRL_ADDR, FILT_START_VAL, FILT_STOP_VAL.
  - The sched_state_e enum.
  - The job_t type (7x32 packed array).
- One sub-module: filter_rr_arb (NUM_REQ request vector + pointer → one-hot grant + index, combinational).

Test Plan:
- Single job: req_i=4'b0010 with job words 0x100..0x106 and cfg_ready_i always 1.
  - Required: gnt_o[1] in cycle 2.
  - Required: 8 cfg beats on consecutive cycles, addresses LUT[0..6] then CTRL with data 0x100..0x106 then START.
  - Required: eot_event_i after 10 cycles → done_o[1]=1, err_o=0.
- Backpressure: cfg_ready_i toggles 1-of-3 cycles.
  - Required: addr/data hold stable while valid is high and ready is low.
  - Required: exactly 8 handshakes and no duplicated word.
- Fairness: req_i=4'b1111 held for 8 jobs.
  - Required: grant order 0,1,2,3,0,1,2,3.
  - Then with req_i=4'b1001 after owner 0: next grant goes to 3.
- Timeout: timeout_cyc_i=16 and no EOT.
  - Required: STOP write exactly 16 cycles after the START handshake, then done_o with err_o=1.
  - Also drive timeout_cyc_i=0 with no EOT for 10000 cycles → required: stays in WAIT_EOT.
- Simultaneous: eot_event_i asserted in the timeout cycle → required: err_o=0 and no STOP write.
- Reset mid-WRITE: rst_i asserted after beat 3.
  - Required: next cycle cfg_valid_o=0, busy_o=0, all outputs 0.
  - Required: a new req is granted starting from rr_ptr=0.
